mpu_alu_issue: RTL and testbench

MPU_ALU_ISSUE -- requirements
Module: mpu_alu_issue

---
 rtl/mpu_alu_issue.sv | 149 ++++++++++++++
 tb/tb_mpu_alu_issue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mpu_alu_issue.sv
// rtl/mpu_alu_issue.sv - issue stage for an external combinational ALU
// Three-cycle operand fetch over a single register-file read port, then execute and writeback.
module mpu_alu_issue (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        host_we,
  input  logic [3:0]  host_addr,
  input  logic [63:0] host_wdata,
  output logic [1:0]  alu_size,
  output logic [3:0]  alu_op,
  output logic [63:0] alu_o0,
  output logic [63:0] alu_o1,
  output logic [63:0] alu_o2,
  output logic [2:0]  alu_s0,
  output logic [2:0]  alu_s1,
  output logic [2:0]  alu_s2,
  input  logic [63:0] alu_res,
  input  logic [7:0]  alu_flags,
  output logic        done,
  output logic [63:0] res_data,
  output logic [7:0]  flags,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, EXEC, WB} state_t;

  state_t      state;
  logic        ready_q;
  logic        done_q;
  logic [3:0]  op_q;
  logic [1:0]  size_q;
  logic [2:0]  s0_q, s1_q, s2_q;
  logic [3:0]  ra_q, rb_q, rc_q, rd_q;
  logic        wf_q;
  logic [63:0] o0_q, o1_q, o2_q;
  logic [63:0] res_q;
  logic [7:0]  flags_q;
  logic [7:0]  pend_q;
  logic [63:0] rf [16];

  logic [3:0]  rd_addr;
  logic [63:0] rd_data;

  // The single read port is steered by the fetch state.
  always_comb begin
    rd_addr = ra_q;
    case (state)
      RD1:     rd_addr = rb_q;
      RD2:     rd_addr = rc_q;
      default: rd_addr = ra_q;
    endcase
  end

  assign rd_data = rf[rd_addr];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= '0;
      size_q  <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      rd_q    <= '0;
      wf_q    <= 1'b0;
      o0_q    <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      pend_q  <= '0;
      for (int i = 0; i < 16; i++) rf[i[3:0]] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          // Host load lands on the acceptance edge too, so RD0..RD2 see it.
          if (host_we) rf[host_addr] <= host_wdata;
          if (ready_q && instr_valid) begin
            op_q    <= instr[31:28];
            size_q  <= instr[27:26];
            s0_q    <= instr[25:23];
            s1_q    <= instr[22:20];
            s2_q    <= instr[19:17];
            ra_q    <= instr[16:13];
            rb_q    <= instr[12:9];
            rc_q    <= instr[8:5];
            rd_q    <= instr[4:1];
            wf_q    <= instr[0];
            ready_q <= 1'b0;
            state   <= RD0;
          end
        end
        RD0: begin
          o0_q  <= rd_data;
          state <= RD1;
        end
        RD1: begin
          o1_q  <= rd_data;
          state <= RD2;
        end
        RD2: begin
          o2_q  <= rd_data;
          state <= EXEC;
        end
        EXEC: begin
          res_q  <= alu_res;
          pend_q <= alu_flags;
          done_q <= 1'b1;
          state  <= WB;
        end
        WB: begin
          rf[rd_q] <= res_q;
          if (wf_q) flags_q <= pend_q;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign busy        = ~ready_q;
  assign done        = done_q;
  assign res_data    = res_q;
  assign flags       = flags_q;
  assign alu_op      = op_q;
  assign alu_size    = size_q;
  assign alu_s0      = s0_q;
  assign alu_s1      = s1_q;
  assign alu_s2      = s2_q;
  assign alu_o0      = o0_q;
  assign alu_o1      = o1_q;
  assign alu_o2      = o2_q;

endmodule

// File: tb/tb_mpu_alu_issue.sv
// tb/tb_mpu_alu_issue.sv - randomized self-checking bench for mpu_alu_issue
// Register file and flags are tracked by an array model; the ALU is an xor stub.
module tb_mpu_alu_issue;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [63:0] host_wdata;
  logic [1:0]  alu_size;
  logic [3:0]  alu_op;
  logic [63:0] alu_o0, alu_o1, alu_o2;
  logic [2:0]  alu_s0, alu_s1, alu_s2;
  logic [63:0] alu_res;
  logic [7:0]  alu_flags;
  logic        done;
  logic [63:0] res_data;
  logic [7:0]  flags;
  logic        busy;

  mpu_alu_issue dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .alu_size(alu_size), .alu_op(alu_op),
    .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_o2(alu_o2),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .done(done), .res_data(res_data), .flags(flags), .busy(busy)
  );

  assign alu_res   = alu_o0 ^ alu_o1 ^ alu_o2;
  assign alu_flags = {alu_op, 1'b0, alu_size, 1'b1};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [63:0] rf_m [16];
  logic [7:0]  flags_m;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [63:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
    rf_m[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) rf_m[i] = '0;
    flags_m = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] sz,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                       input logic [3:0] rd, input logic wf,
                       input logic hw, input logic [3:0] ha, input logic [63:0] hd,
                       input logic mid);
    int k;
    int lat;
    logic [63:0] er;
    logic [7:0]  ef;
    logic [2:0]  s0, s1, s2;
    logic [3:0]  ma;
    s0 = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
    ma = 4'($urandom);
    k = 0;
    while (!instr_ready && k < 30) begin tick(); k++; end
    chk("ready_wait", {63'd0, instr_ready}, 64'd1);
    instr = {op, sz, s0, s1, s2, ra, rb, rc, rd, wf};
    instr_valid = 1'b1;
    host_we = hw; host_addr = ha; host_wdata = hd;
    if (hw) rf_m[ha] = hd;
    er = rf_m[ra] ^ rf_m[rb] ^ rf_m[rc];
    ef = {op, 1'b0, sz, 1'b1};
    tick();
    instr_valid = 1'b0;
    host_we = 1'b0;
    instr = 32'($urandom);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("alu_ctrl", {42'd0, alu_op, alu_size, alu_s0, alu_s1, alu_s2, 7'd0}, {42'd0, op, sz, s0, s1, s2, 7'd0});
    tick();
    lat = 1;
    if (mid) begin
      host_we = 1'b1; host_addr = ma; host_wdata = {$urandom, $urandom};
    end
    while (!done && lat < 12) begin
      tick();
      host_we = 1'b0;
      lat++;
    end
    chk("done_latency", 64'(lat), 64'd4);
    chk("res_data", res_data, er);
    tick();
    rf_m[rd] = er;
    if (wf) flags_m = ef;
    chk("done_pulse_end", {63'd0, done}, 64'd0);
    chk("ready_after_wb", {63'd0, instr_ready}, 64'd1);
    chk("flags", {56'd0, flags}, {56'd0, flags_m});
    chk("rf_rd", dut.rf[rd], rf_m[rd]);
    if (mid) chk("rf_ignored_host", dut.rf[ma], rf_m[ma]);
  endtask

  initial begin
    int cyc;
    int last;
    int nacc;
    logic [63:0] e5;
    sys_rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    model_clear();
    repeat (3) tick();
    chk("rst_ready", {63'd0, instr_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    sys_rst_n = 1'b1;
    tick();
    chk("ready_after_release", {63'd0, instr_ready}, 64'd1);
    chk("flags_reset", {56'd0, flags}, 64'd0);
    chk("res_reset", res_data, 64'd0);

    // Directed scenarios
    host_wr(4'd1, 64'h55);
    host_wr(4'd2, 64'hAA00);
    host_wr(4'd3, 64'h550000);
    issue(4'd1, 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 4'd0, 64'd0, 1'b0);
    chk("rf4_value", dut.rf[4], 64'h55AA55);
    chk("flags_value", {56'd0, flags}, 64'h11);
    issue(4'd1, 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    issue(4'd7, 2'd2, 4'd2, 4'd3, 4'd0, 4'd9, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
    chk("flags_kept_wf0", {56'd0, flags}, 64'h11);
    issue(4'd2, 2'd1, 4'd1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 4'd1, 64'hFF, 1'b0);
    chk("rf1_same_edge", dut.rf[1], 64'hFF);
    issue(4'd3, 2'd3, 4'd1, 4'd2, 4'd3, 4'd6, 1'b1, 1'b0, 4'd0, 64'd0, 1'b1);

    // Randomized instructions with random loads
    for (int i = 0; i < 16; i++) host_wr(4'(i), {$urandom, $urandom});
    for (int n = 0; n < 24; n++)
      issue(4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 1'($urandom), ($urandom % 3) == 0, 4'($urandom),
            {$urandom, $urandom}, ($urandom % 3) == 0);

    // Back-to-back with instr_valid held high
    instr = {4'd5, 2'd1, 9'd0, 4'd1, 4'd2, 4'd3, 4'd5, 1'b1};
    e5 = rf_m[1] ^ rf_m[2] ^ rf_m[3];
    instr_valid = 1'b1;
    cyc = 0; last = 0; nacc = 0;
    while (nacc < 4 && cyc < 60) begin
      if (instr_ready) begin
        if (nacc > 0) chk("accept_gap", 64'(cyc - last), 64'd6);
        last = cyc;
        nacc++;
      end
      tick();
      cyc++;
    end
    instr_valid = 1'b0;
    chk("accept_count", 64'(nacc), 64'd4);
    cyc = 0;
    while (!instr_ready && cyc < 20) begin tick(); cyc++; end
    rf_m[5] = e5;
    flags_m = {4'd5, 1'b0, 2'd1, 1'b1};
    chk("stream_rf5", dut.rf[5], rf_m[5]);
    chk("stream_flags", {56'd0, flags}, {56'd0, flags_m});

    // Reset while in EXEC aborts the instruction
    instr = {4'd9, 2'd0, 9'd0, 4'd1, 4'd2, 4'd3, 4'd6, 1'b1};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b0;
    tick();
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_ready", {63'd0, instr_ready}, 64'd0);
    tick();
    sys_rst_n = 1'b1;
    model_clear();
    tick();
    chk("abort_ready_release", {63'd0, instr_ready}, 64'd1);
    chk("abort_no_done", {63'd0, done}, 64'd0);
    for (int i = 0; i < 16; i++) chk("abort_rf_clear", dut.rf[i], rf_m[i]);
    chk("abort_flags", {56'd0, flags}, 64'd0);
    chk("abort_res", res_data, 64'd0);
    issue(4'd1, 2'd0, 4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 4'd0, 64'h1234, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
